huffman_decode: RTL and testbench
=================================

Name: huffman_decode

Overview:
- Receive-side counterpart of the serial Huffman encoder: consumes the 1-bit code stream and its strobe, and emits 4-bit symbols.
- Decoding is canonical-Huffman: the host loads one code length per symbol, the block builds its decode tables internally, then decodes bit-serially.
- Sits at the far end of the serial link, feeding symbols to the consumer.

Parameters:
- SYM_W, 4, symbol width; number of symbols NSYM = 2**SYM_W = 16.
- MAX_LEN, 15, maximum code length in bits; code register width.
- LEN_W, 4, width of one code-length entry; value 0 = symbol unused.

Ports:
- Clk  input  1  clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Len_wr  input  1  write strobe for a code-length entry.
- Len_sym  input  SYM_W  symbol index for Len_wr.
- Len_val  input  LEN_W  code length for Len_sym.
- Start  input  1  one-cycle pulse: build tables, then enter decode.
- Bit_in  input  1  serial code bit.
- Bit_valid  input  1  Bit_in qualifier.
- Bit_ready  output  1  decoder accepts a bit this cycle.
- Sym_out  output  SYM_W  decoded symbol.
- Sym_valid  output  1  one-cycle pulse, Sym_out valid.
- Busy  output  1  table build in progress.
- Err  output  1  sticky invalid-code flag.

Behaviour:
- Reset (async, Reset=0):
  - State IDLE; all length entries 0.
  - Bit_ready=0, Sym_valid=0, Sym_out=0, Busy=0, Err=0.
- States: IDLE, COUNT, FIRST, SORT, DECODE.
- IDLE:
  - Len_wr writes the length table; Len_wr is ignored in every other state.
  - Start -> COUNT, Busy=1, Err cleared.
- COUNT: 16 cycles, one symbol per cycle; count[l]++ for each nonzero length l. -> FIRST.
- FIRST: MAX_LEN cycles, for l = 1..MAX_LEN:
  - first[1]=0; first[l] = (first[l-1]+count[l-1])<<1.
  - offset[1]=0; offset[l] = offset[l-1]+count[l-1].
  - -> SORT.
- SORT:
  - For l = 1..MAX_LEN, s = 0..15: if len[s]==l, write s into sorted[ptr++].
  - 240 cycles; total build = 271 cycles from Start.
  - -> DECODE, Busy=0.
- DECODE:
  - Bit_ready=1. A bit is accepted when Bit_valid && Bit_ready.
  - On accept: code = (code<<1)|Bit_in, clen++.
  - Match test uses the new code and clen: d = code - first[clen]; match if d < count[clen].
  - On match: Sym_out = sorted[offset[clen]+d], Sym_valid=1 in the next cycle (latency 1 from the final bit); code and clen cleared.
  - No match and clen==MAX_LEN: Err=1, code/clen cleared, -> IDLE; Bit_ready drops the next cycle.
  - Back-to-back 1-bit codes give one Sym_valid per accepted bit; there is no output backpressure.
- Start during DECODE: partial code discarded, -> COUNT (rebuild); the length table is retained.
- Start during COUNT/FIRST/SORT: ignored.
- Bit_valid in a non-DECODE state: ignored, never consumed.
- All-zero length table: DECODE never matches; Err after MAX_LEN bits.
- Arithmetic:
  - first/code are MAX_LEN+1 bits wide.
  - count is 5 bits (max 16); offset and ptr are 5 bits.
  - Oversubscribed tables (Kraft sum > 1) are not checked; decode result is undefined but must not hang.
- Reset mid-build or mid-decode: immediate return to reset state, length table cleared.

Optional Feature:
- Macro HUFF_DEC_SYMCNT_EN.
- Defined:
  - Extra output port Sym_cnt [15:0].
  - Increments on each Sym_valid, wraps 0xFFFF->0.
  - Cleared by Reset and by Start.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package huff_pkg:
  - SYM_W, NSYM, MAX_LEN, LEN_W constants.
  - State enum for IDLE/COUNT/FIRST/SORT/DECODE.
  - Shared with the encoder side.
- Sub-module huff_canon_builder:
  - Owns COUNT/FIRST/SORT and the count/first/offset/sorted tables.
  - Exposes a done pulse and read ports.
- huffman_decode keeps the top FSM, shift logic and outputs.

Test Plan:
- Basic decode: lengths s0=1, s1=2, s2=3, s3=3, rest 0; Start; wait for Busy=0 (271 cycles). Bits 0,1,0,1,1,1,1,1,0 -> Sym_out 0,1,3,2, each Sym_valid one cycle after the last bit of its code.
- Stalls: same table, Bit_valid toggled 1/0 every cycle -> identical symbol sequence, no extra Sym_valid.
- Invalid code: lengths s0=1, s1=2 only; feed 15 ones -> no Sym_valid, Err=1 after the 15th bit, Bit_ready=0 next cycle. New Start clears Err.
- Flat table: all 16 symbols length 4; bits for code 1010 -> Sym_out=10; code 1111 -> Sym_out=15.
- Restart mid-code: feed bits 1,1; pulse Start -> Busy=1, partial code dropped. After rebuild, bit 0 -> Sym_out=0.
- Reset mid-SORT: Reset=0 -> Busy=0, Bit_ready=0, table cleared. With HUFF_DEC_SYMCNT_EN defined: Sym_cnt=0, and 4 decoded symbols give Sym_cnt=4.

Source files
------------

// File: rtl/huff_pkg.sv
// Shared constants and state encoding for the canonical-Huffman encoder/decoder pair.
// State values are plain constants so legacy code can compare them directly.
package huff_pkg;

  localparam int SYM_W   = 4;
  localparam int NSYM    = 2**SYM_W;
  localparam int MAX_LEN = 15;
  localparam int LEN_W   = 4;
  localparam int NLEN    = 2**LEN_W;
  localparam int CNT_W   = 5;
  localparam int CODE_W  = MAX_LEN + 1;
  localparam int STEP_W  = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_COUNT  = 3'd1;
  localparam logic [2:0] ST_FIRST  = 3'd2;
  localparam logic [2:0] ST_SORT   = 3'd3;
  localparam logic [2:0] ST_DECODE = 3'd4;

  localparam logic [STEP_W-1:0] COUNT_LAST = STEP_W'(NSYM - 1);
  localparam logic [STEP_W-1:0] FIRST_LAST = STEP_W'(MAX_LEN - 1);
  localparam logic [STEP_W-1:0] SORT_LAST  = STEP_W'(MAX_LEN * NSYM - 1);

  function automatic logic is_build(input logic [2:0] st);
    return st inside {ST_COUNT, ST_FIRST, ST_SORT};
  endfunction

endpackage

// File: rtl/huff_canon_builder.sv
// Owns the code-length table and builds the canonical decode tables
// (count/first/offset/sorted) while the top FSM sits in COUNT, FIRST and SORT.
module huff_canon_builder
  import huff_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              i_len_wr,
  input  logic [SYM_W-1:0]  i_len_sym,
  input  logic [LEN_W-1:0]  i_len_val,
  input  logic              i_start,
  input  logic [2:0]        i_state,
  output logic              o_last,
  input  logic [LEN_W-1:0]  i_rd_len,
  input  logic [SYM_W-1:0]  i_rd_idx,
  output logic [CNT_W-1:0]  o_count,
  output logic [CODE_W-1:0] o_first,
  output logic [CNT_W-1:0]  o_offset,
  output logic [SYM_W-1:0]  o_sym
);

  logic [LEN_W-1:0]  r_len    [NSYM];
  logic [CNT_W-1:0]  r_count  [NLEN];
  logic [CODE_W-1:0] r_first  [NLEN];
  logic [CNT_W-1:0]  r_offset [NLEN];
  logic [SYM_W-1:0]  r_sorted [NSYM];
  logic [STEP_W-1:0] r_step;
  logic [CNT_W-1:0]  r_ptr;

  logic [LEN_W-1:0]  w_cnt_len;
  logic [LEN_W-1:0]  w_fl_prev;
  logic [LEN_W-1:0]  w_fl;
  logic [CODE_W-1:0] w_first_sum;
  logic [CODE_W-1:0] w_first_nx;
  logic [CNT_W-1:0]  w_offset_nx;
  logic [LEN_W-1:0]  w_sort_len;
  logic [SYM_W-1:0]  w_sort_sym;
  logic              w_sort_hit;

  // COUNT walks symbols by step; SORT splits step into (length-1, symbol).
  assign w_cnt_len   = r_len[r_step[SYM_W-1:0]];
  assign w_fl_prev   = r_step[LEN_W-1:0];
  assign w_fl        = w_fl_prev + LEN_W'(1);
  assign w_first_sum = r_first[w_fl_prev] + {{(CODE_W-CNT_W){1'b0}}, r_count[w_fl_prev]};
  assign w_first_nx  = (w_fl_prev == '0) ? '0 : (w_first_sum << 1);
  assign w_offset_nx = (w_fl_prev == '0) ? '0 : (r_offset[w_fl_prev] + r_count[w_fl_prev]);
  assign w_sort_len  = r_step[STEP_W-1:SYM_W] + LEN_W'(1);
  assign w_sort_sym  = r_step[SYM_W-1:0];
  assign w_sort_hit  = (r_len[w_sort_sym] == w_sort_len) && !r_ptr[CNT_W-1];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    o_last = 1'b0;
    case (i_state)
      ST_COUNT: o_last = (r_step == COUNT_LAST);
      ST_FIRST: o_last = (r_step == FIRST_LAST);
      ST_SORT:  o_last = (r_step == SORT_LAST);
      default:  o_last = 1'b0;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_step <= '0;
      r_ptr  <= '0;
      for (int i = 0; i < NSYM; i++) r_len[i] <= '0;
      for (int i = 0; i < NLEN; i++) begin
        r_count[i]  <= '0;
        r_first[i]  <= '0;
        r_offset[i] <= '0;
      end
    end else begin
      if (i_len_wr) r_len[i_len_sym] <= i_len_val;
      if (i_start) begin
        r_step <= '0;
        r_ptr  <= '0;
        for (int i = 0; i < NLEN; i++) r_count[i] <= '0;
      end else begin
        if (is_build(i_state)) r_step <= o_last ? '0 : r_step + STEP_W'(1);
        case (i_state)
          ST_COUNT: if (w_cnt_len != '0) r_count[w_cnt_len] <= r_count[w_cnt_len] + CNT_W'(1);
          ST_FIRST: begin
            r_first[w_fl]  <= w_first_nx;
            r_offset[w_fl] <= w_offset_nx;
          end
          ST_SORT:  if (w_sort_hit) r_ptr <= r_ptr + CNT_W'(1);
          default:  ;
        endcase
      end
    end
  end

  // NOTE: the sorted table has no reset; every build rewrites the slots a later match can reach.
  always_ff @(posedge Clk) begin
    if (i_state == ST_SORT && w_sort_hit) r_sorted[r_ptr[SYM_W-1:0]] <= w_sort_sym;
  end

  assign o_count  = r_count[i_rd_len];
  assign o_first  = r_first[i_rd_len];
  assign o_offset = r_offset[i_rd_len];
  assign o_sym    = r_sorted[i_rd_idx];

endmodule

// File: rtl/huffman_decode.sv
// Bit-serial canonical-Huffman decoder: top FSM, code shift register and outputs.
// Optional symbol counter output enabled by defining HUFF_DEC_SYMCNT_EN.
module huffman_decode
  import huff_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Len_wr,
  input  logic [SYM_W-1:0] Len_sym,
  input  logic [LEN_W-1:0] Len_val,
  input  logic             Start,
  input  logic             Bit_in,
  input  logic             Bit_valid,
  output logic             Bit_ready,
  output logic [SYM_W-1:0] Sym_out,
  output logic             Sym_valid,
  output logic             Busy,
  output logic             Err
`ifdef HUFF_DEC_SYMCNT_EN
  ,
  output logic [15:0]      Sym_cnt
`endif
);

  logic [2:0]        r_state;
  logic [CODE_W-1:0] r_code;
  logic [LEN_W-1:0]  r_clen;
  logic              r_sym_valid;
  logic [SYM_W-1:0]  r_sym_out;
  logic              r_err;

  logic              w_last;
  logic              w_start_ok;
  logic              w_accept;
  logic              w_hit;
  logic [CODE_W-1:0] w_code_nx;
  logic [LEN_W-1:0]  w_clen_nx;
  logic [CNT_W-1:0]  w_count;
  logic [CODE_W-1:0] w_first;
  logic [CNT_W-1:0]  w_offset;
  logic [SYM_W-1:0]  w_sym;
  logic [CODE_W-1:0] w_d;
  logic [CNT_W-1:0]  w_idx;
  logic              w_match;

  assign Bit_ready  = (r_state == ST_DECODE);
  assign Busy       = is_build(r_state);
  assign Err        = r_err;
  assign Sym_out    = r_sym_out;
  assign Sym_valid  = r_sym_valid;

  assign w_start_ok = Start && (r_state == ST_IDLE || r_state == ST_DECODE);
  assign w_accept   = Bit_ready && Bit_valid && !Start;

  // The match test looks at the code as it will be after this bit is shifted in.
  assign w_code_nx  = (r_code << 1) | CODE_W'(Bit_in);
  assign w_clen_nx  = r_clen + LEN_W'(1);
  assign w_d        = w_code_nx - w_first;
  assign w_idx      = w_offset + w_d[CNT_W-1:0];
  // An index past the table only happens for oversubscribed tables; treat it as no match.
  assign w_match    = (w_d < {{(CODE_W-CNT_W){1'b0}}, w_count}) && !w_idx[CNT_W-1];
  assign w_hit      = w_accept && w_match;

  huff_canon_builder u_builder (
    .Clk       (Clk),
    .Reset     (Reset),
    .i_len_wr  (Len_wr && r_state == ST_IDLE),
    .i_len_sym (Len_sym),
    .i_len_val (Len_val),
    .i_start   (w_start_ok),
    .i_state   (r_state),
    .o_last    (w_last),
    .i_rd_len  (w_clen_nx),
    .i_rd_idx  (w_idx[SYM_W-1:0]),
    .o_count   (w_count),
    .o_first   (w_first),
    .o_offset  (w_offset),
    .o_sym     (w_sym)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state     <= ST_IDLE;
      r_code      <= '0;
      r_clen      <= '0;
      r_sym_valid <= 1'b0;
      r_sym_out   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_sym_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (Start) begin
            r_state <= ST_COUNT;
            r_err   <= 1'b0;
          end
        end
        ST_COUNT: if (w_last) r_state <= ST_FIRST;
        ST_FIRST: if (w_last) r_state <= ST_SORT;
        ST_SORT:  if (w_last) r_state <= ST_DECODE;
        ST_DECODE: begin
          if (Start) begin
            r_state <= ST_COUNT;
            r_err   <= 1'b0;
            r_code  <= '0;
            r_clen  <= '0;
          end else if (w_accept) begin
            if (w_match) begin
              r_sym_out   <= w_sym;
              r_sym_valid <= 1'b1;
              r_code      <= '0;
              r_clen      <= '0;
            end else if (w_clen_nx == LEN_W'(MAX_LEN)) begin
              r_err   <= 1'b1;
              r_state <= ST_IDLE;
              r_code  <= '0;
              r_clen  <= '0;
            end else begin
              r_code <= w_code_nx;
              r_clen <= w_clen_nx;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef HUFF_DEC_SYMCNT_EN
  logic [15:0] r_sym_cnt;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)          r_sym_cnt <= '0;
    else if (w_start_ok) r_sym_cnt <= '0;
    else if (w_hit)      r_sym_cnt <= r_sym_cnt + 16'd1;
  end

  assign Sym_cnt = r_sym_cnt;
`endif

endmodule

// File: tb/tb_huffman_decode.sv
// Self-checking bench for huffman_decode: canonical-code reference model plus directed vectors.
module tb_huffman_decode;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Len_wr = 1'b0;
  logic [3:0] Len_sym = '0;
  logic [3:0] Len_val = '0;
  logic       Start = 1'b0;
  logic       Bit_in = 1'b0;
  logic       Bit_valid = 1'b0;
  logic       Bit_ready;
  logic [3:0] Sym_out;
  logic       Sym_valid;
  logic       Busy;
  logic       Err;
`ifdef HUFF_DEC_SYMCNT_EN
  logic [15:0] Sym_cnt;
`endif

  int checks = 0;
  int failures = 0;

  huffman_decode dut (
`ifdef HUFF_DEC_SYMCNT_EN
    .Sym_cnt   (Sym_cnt),
`endif
    .Clk       (Clk),
    .Reset     (Reset),
    .Len_wr    (Len_wr),
    .Len_sym   (Len_sym),
    .Len_val   (Len_val),
    .Start     (Start),
    .Bit_in    (Bit_in),
    .Bit_valid (Bit_valid),
    .Bit_ready (Bit_ready),
    .Sym_out   (Sym_out),
    .Sym_valid (Sym_valid),
    .Busy      (Busy),
    .Err       (Err)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: canonical codes assigned by walking (length, symbol) order,
  // decoding by growing a prefix until it equals some symbol's code.
  typedef enum {M_IDLE, M_BUILD, M_DEC} mode_e;
  mode_e m_mode;
  int    m_lens  [16];
  int    m_codes [16];
  int    m_build_left, m_pval, m_plen, m_sym, m_cnt;
  bit    m_valid, m_err;
  int    got_syms[$];

  function automatic void model_reset();
    m_mode = M_IDLE;
    foreach (m_lens[s]) m_lens[s] = 0;
    m_build_left = 0; m_pval = 0; m_plen = 0;
    m_sym = 0; m_cnt = 0; m_valid = 0; m_err = 0;
  endfunction

  function automatic void model_build();
    int code = 0;
    for (int l = 1; l <= 15; l++) begin
      for (int s = 0; s < 16; s++)
        if (m_lens[s] == l) begin m_codes[s] = code; code++; end
      code = code * 2;
    end
    m_mode = M_BUILD; m_build_left = 271;
    m_err = 0; m_pval = 0; m_plen = 0; m_cnt = 0;
  endfunction

  function automatic void model_bit(input bit b);
    int hit = -1;
    m_pval = m_pval * 2 + int'(b);
    m_plen++;
    for (int s = 0; s < 16; s++)
      if (hit < 0 && m_lens[s] == m_plen && m_codes[s] == m_pval) hit = s;
    if (hit >= 0) begin
      m_valid = 1; m_sym = hit; m_cnt = (m_cnt + 1) & 16'hffff;
      m_pval = 0; m_plen = 0;
    end else if (m_plen == 15) begin
      m_err = 1; m_mode = M_IDLE; m_pval = 0; m_plen = 0;
    end
  endfunction

  // Compare process: outputs against the model, then advance the model for the next edge.
  always @(negedge Clk) begin
    if (!Reset) model_reset();
    check("bit_ready", Bit_ready, m_mode == M_DEC);
    check("busy", Busy, m_mode == M_BUILD);
    check("err", Err, m_err);
    check("sym_valid", Sym_valid, m_valid);
    check("sym_out", Sym_out, m_sym);
`ifdef HUFF_DEC_SYMCNT_EN
    check("sym_cnt", Sym_cnt, m_cnt);
`endif
    if (Sym_valid === 1'b1) got_syms.push_back(int'(Sym_out));
    m_valid = 0;
    if (Reset) begin
      case (m_mode)
        M_IDLE: begin
          if (Len_wr) m_lens[Len_sym] = int'(Len_val);
          if (Start) model_build();
        end
        M_BUILD: begin
          m_build_left--;
          if (m_build_left == 0) m_mode = M_DEC;
        end
        M_DEC: begin
          if (Start) model_build();
          else if (Bit_valid) model_bit(Bit_in);
        end
        default: m_mode = M_IDLE;
      endcase
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic load_table(input int t[16]);
    for (int s = 0; s < 16; s++) begin
      Len_wr = 1'b1; Len_sym = 4'(s); Len_val = 4'(t[s]);
      tick();
    end
    Len_wr = 1'b0;
  endtask

  task automatic start_build();
    int n = 0;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("busy_after_start", Busy, 1);
    check("err_after_start", Err, 0);
    while (Busy === 1'b1 && n < 400) begin
      tick();
      n++;
    end
    check("build_cycles", n, 271);
    check("ready_after_build", Bit_ready, 1);
  endtask

  // Sends the low n bits of v, most significant first; stall inserts an idle cycle per bit.
  task automatic send(input int n, input logic [31:0] v, input bit stall);
    for (int i = n - 1; i >= 0; i--) begin
      Bit_in = v[i]; Bit_valid = 1'b1;
      tick();
      if (stall) begin
        Bit_valid = 1'b0;
        tick();
      end
    end
    Bit_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic check_syms(input string name, input int exp[$]);
    check({name, "_count"}, got_syms.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got_syms.size(); i++)
      check(name, got_syms[i], exp[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_basic[16];
    int t_two[16];
    int t_flat[16];
    foreach (t_basic[s]) begin t_basic[s] = 0; t_two[s] = 0; t_flat[s] = 4; end
    t_basic[0] = 1; t_basic[1] = 2; t_basic[2] = 3; t_basic[3] = 3;
    t_two[0] = 1; t_two[1] = 2;

    #1 Reset = 1'b0;
    tick(); tick();
    check("rst_busy", Busy, 0);
    check("rst_ready", Bit_ready, 0);
    check("rst_sym_out", Sym_out, 0);
    Reset = 1'b1;
    tick();

    // Basic decode: codes 0, 10, 110, 111.
    load_table(t_basic);
    start_build();
    got_syms.delete();
    send(9, 32'b010111110, 0);
    check_syms("basic", '{0, 1, 3, 2});

    // Length writes outside IDLE must not disturb the table.
    Len_wr = 1'b1; Len_sym = 4'd0; Len_val = 4'd5;
    tick();
    Len_wr = 1'b0;

    // Stalled input stream.
    got_syms.delete();
    send(9, 32'b010111110, 1);
    check_syms("stall", '{0, 1, 3, 2});

    // Restart mid-code: partial "11" must be dropped.
    got_syms.delete();
    send(2, 32'b11, 0);
    start_build();
    send(1, 32'b0, 0);
    check_syms("restart", '{0});
    check("restart_sym_out", Sym_out, 0);

    // Invalid code stream with a two-symbol table.
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    tick();
    load_table(t_two);
    start_build();
    got_syms.delete();
    send(15, 32'h7fff, 0);
    check("invalid_err", Err, 1);
    check("invalid_ready", Bit_ready, 0);
    check("invalid_syms", got_syms.size(), 0);

    // Flat table: every symbol 4 bits, code equals symbol; Start also clears Err.
    load_table(t_flat);
    start_build();
    got_syms.delete();
    send(4, 32'b1010, 0);
    send(4, 32'b1111, 0);
    check_syms("flat", '{10, 15});
    check("flat_sym_out", Sym_out, 15);

    // Reset during SORT.
    Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (100) tick();
    check("mid_sort_busy", Busy, 1);
    Reset = 1'b0;
    #2;
    check("reset_busy", Busy, 0);
    check("reset_ready", Bit_ready, 0);
    tick();
    Reset = 1'b1;
    tick();
`ifdef HUFF_DEC_SYMCNT_EN
    check("reset_sym_cnt", Sym_cnt, 0);
`endif
    // Cleared table: nothing ever matches.
    start_build();
    got_syms.delete();
    send(15, 32'h0, 0);
    check("cleared_err", Err, 1);
    check("cleared_syms", got_syms.size(), 0);

`ifdef HUFF_DEC_SYMCNT_EN
    load_table(t_basic);
    start_build();
    got_syms.delete();
    send(9, 32'b010111110, 0);
    check("sym_cnt_four", Sym_cnt, 4);
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
